switch_input_ctrl: RTL and testbench



---
 rtl/switch_input_ctrl_pkg.sv | 26 ++
 rtl/switch_input_ctrl_if.sv | 35 +++
 rtl/switch_input_ctrl_sync2.sv | 34 +++
 rtl/switch_input_ctrl.sv | 115 +++++++++++
 tb/tb_switch_input_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/switch_input_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : switch_input_ctrl_pkg                                      |
// | Purpose : Shared definitions for the switch input peripheral: IO     |
// |           register offsets, debounce default, FSM state encoding.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package switch_input_ctrl_pkg;

  // IO register offsets within the switch peripheral window
  localparam logic [1:0] SW_DATA_OFF = 2'b00;
  localparam logic [1:0] SW_STAT_OFF = 2'b10;

  // About 1 ms of stable input at the CPU clock
  localparam int DEFAULT_DEBOUNCE_CYCLES = 20000;

  typedef logic [1:0] sw_addr_t;

  // Debounce FSM states
  typedef enum logic {
    DB_IDLE  = 1'b0,
    DB_COUNT = 1'b1
  } db_state_e;

endpackage
`default_nettype wire

// File: rtl/switch_input_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : switch_input_ctrl_if                                       |
// | Purpose : IO read-side bus between the CPU IO decode and the switch  |
// |           peripheral (chip select, read strobe, address, read data). |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface switch_input_ctrl_if #(
  parameter int WIDTH = 16
);
  import switch_input_ctrl_pkg::*;

  logic             switchcs;
  logic             switchrd;
  sw_addr_t         switchaddr;
  logic [WIDTH-1:0] switchrdata;

  // CPU / IO decode side
  modport master (
    output switchcs,
    output switchrd,
    output switchaddr,
    input  switchrdata
  );

  // Peripheral side
  modport slave (
    input  switchcs,
    input  switchrd,
    input  switchaddr,
    output switchrdata
  );

endinterface
`default_nettype wire

// File: rtl/switch_input_ctrl_sync2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sync2                                                      |
// | Purpose : WIDTH-bit two-flop synchronizer with async active-high     |
// |           reset, for bringing board inputs into the clock domain.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module sync2 #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First stage may go metastable; second stage gives a settled copy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/switch_input_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : switch_input_ctrl                                          |
// | Purpose : Memory-mapped switch input peripheral. Synchronizes and    |
// |           debounces the board switches, holds a stable snapshot and |
// |           a sticky changed flag cleared by a status read.           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module switch_input_ctrl
  import switch_input_ctrl_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 15
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [WIDTH-1:0]    switch_i,
  switch_input_ctrl_if.slave  bus,
  output logic                switch_changed
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [WIDTH-1:0] sw_sync;

  db_state_e        state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             changed_q, changed_d;

  logic             set_chg;
  logic             rd_en;
  logic             stat_rd;

  // The synchronizer is the only consumer of the raw switch pins
  sync2 #(
    .WIDTH (WIDTH)
  ) u_sync2 (
    .clock (clock),
    .reset (reset),
    .d_i   (switch_i),
    .q_o   (sw_sync)
  );

  // State registers for the debounce FSM, snapshot and changed flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= DB_IDLE;
      cand_q    <= '0;
      stable_q  <= '0;
      cnt_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      changed_q <= changed_d;
    end
  end

  // Debounce: one shared counter, any bit change restarts the count
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    set_chg  = 1'b0;
    case (state_q)
      DB_IDLE: begin
        if (sw_sync != stable_q) begin
          cand_d  = sw_sync;
          cnt_d   = '0;
          state_d = DB_COUNT;
        end
      end
      DB_COUNT: begin
        if (sw_sync != cand_q) begin
          cand_d = sw_sync;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          // A return to the old value still completes; it just rewrites stable
          stable_d = cand_q;
          state_d  = DB_IDLE;
          set_chg  = (cand_q != stable_q);
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = DB_IDLE;
      end
    endcase
  end

  // Same-cycle read mux and changed-flag update (set beats clear)
  always_comb begin
    rd_en           = bus.switchcs & bus.switchrd;
    stat_rd         = rd_en && (bus.switchaddr == SW_STAT_OFF);
    bus.switchrdata = '0;
    if (rd_en && (bus.switchaddr == SW_DATA_OFF)) begin
      bus.switchrdata = stable_q;
    end else if (stat_rd) begin
      bus.switchrdata = {{(WIDTH-1){1'b0}}, changed_q};
    end
    changed_d = set_chg | (changed_q & ~stat_rd);
  end

  assign switch_changed = changed_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_input_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_switch_input_ctrl                                       |
// | Purpose : Directed and randomized bench for switch_input_ctrl with   |
// |           a window-based reference model of the debounce rules.     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_switch_input_ctrl;

  localparam int W  = 16;
  localparam int DB = 8;

  logic          clock;
  logic          reset;
  logic [W-1:0]  switch_i;
  logic          switch_changed;

  int checks = 0;
  int errors = 0;

  // Reference model: synchronizer delay plus an observation window
  logic [W-1:0]  m_s1, m_s2;
  logic [W-1:0]  m_stable;
  logic          m_changed;
  bit            m_open;
  logic [W-1:0]  m_val;
  int            m_len;

  switch_input_ctrl_if #(.WIDTH(W)) sif ();

  switch_input_ctrl #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .switch_i       (switch_i),
    .bus            (sif),
    .switch_changed (switch_changed)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_changed = 1'b0;
    m_open = 1'b0; m_val = '0; m_len = 0;
  endtask

  function automatic logic [W-1:0] exp_rd();
    if (!(sif.switchcs && sif.switchrd)) return '0;
    if (sif.switchaddr == 2'b00) return m_stable;
    if (sif.switchaddr == 2'b10) return {{(W-1){1'b0}}, m_changed};
    return '0;
  endfunction

  task automatic set_rd(input logic cs, input logic rd, input logic [1:0] addr);
    sif.switchcs = cs; sif.switchrd = rd; sif.switchaddr = addr;
  endtask

  // Advance one clock: update the model from pre-edge inputs, then compare
  task automatic tick();
    logic [W-1:0] v;
    bit clr, acc_set;
    if (!reset) begin
      v = m_s2; m_s2 = m_s1; m_s1 = switch_i;
      clr = sif.switchcs && sif.switchrd && (sif.switchaddr == 2'b10);
      acc_set = 1'b0;
      // Accept a value once DB+1 consecutive identical samples are seen
      if (!m_open) begin
        if (v != m_stable) begin m_open = 1'b1; m_val = v; m_len = 1; end
      end else if (v != m_val) begin
        m_val = v; m_len = 1;
      end else begin
        m_len++;
        if (m_len == DB + 1) begin
          acc_set = (m_val != m_stable);
          m_stable = m_val;
          m_open = 1'b0;
        end
      end
      m_changed = acc_set | (m_changed & ~clr);
    end
    @(posedge clock);
    #1;
    chk("model_rdata", sif.switchrdata, exp_rd());
    chk("model_changed", {{(W-1){1'b0}}, switch_changed}, {{(W-1){1'b0}}, m_changed});
  endtask

  task automatic pulse_reset();
    reset = 1'b1; model_reset(); #1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    clock = 1'b0; reset = 1'b1; switch_i = '0; set_rd(1'b0, 1'b0, 2'b00);
    model_reset();
    repeat (2) tick();
    reset = 1'b0;

    // 1. Reset behaviour with all switches on
    switch_i = 16'hFFFF;
    repeat (5) tick();
    #2 reset = 1'b1; model_reset();
    set_rd(1'b1, 1'b1, 2'b00); #1;
    chk("rst_data", sif.switchrdata, 16'h0000);
    chk("rst_changed", {15'b0, switch_changed}, 16'h0000);
    set_rd(1'b1, 1'b1, 2'b10); #1;
    chk("rst_stat", sif.switchrdata, 16'h0000);
    set_rd(1'b1, 1'b1, 2'b00);
    repeat (3) tick();
    reset = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 10) chk("rst_rel_c10", sif.switchrdata, 16'h0000);
      if (k == 11) begin
        chk("rst_rel_c11", sif.switchrdata, 16'hFFFF);
        chk("rst_rel_chg", {15'b0, switch_changed}, 16'h0001);
      end
    end

    // 2. Clean change from zero
    switch_i = 16'h0000; pulse_reset();
    switch_i = 16'hA5A5; set_rd(1'b1, 1'b1, 2'b00);
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 10) chk("clean_c10", sif.switchrdata, 16'h0000);
      if (k == 11) chk("clean_c11", sif.switchrdata, 16'hA5A5);
    end
    set_rd(1'b1, 1'b1, 2'b10); #1;
    chk("clean_stat", sif.switchrdata, 16'h0001);
    tick();
    chk("clean_cleared", {15'b0, switch_changed}, 16'h0000);

    // 3. Bounce on bit 0
    switch_i = 16'h0000; pulse_reset();
    set_rd(1'b1, 1'b1, 2'b00);
    for (int s = 0; s < 10; s++) begin
      switch_i = (s % 2 == 0) ? 16'h0001 : 16'h0000;
      repeat (3) begin
        tick();
        chk("bounce_hold", sif.switchrdata, 16'h0000);
      end
    end
    switch_i = 16'h0001;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 10) chk("bounce_c10", sif.switchrdata, 16'h0000);
      if (k == 11) begin
        chk("bounce_c11", sif.switchrdata, 16'h0001);
        chk("bounce_chg", {15'b0, switch_changed}, 16'h0001);
      end
    end
    set_rd(1'b1, 1'b1, 2'b10); tick();
    set_rd(1'b1, 1'b1, 2'b00);
    repeat (5) begin
      tick();
      chk("bounce_once", {15'b0, switch_changed}, 16'h0000);
    end

    // 4. Glitch back to the old stable value
    switch_i = 16'h00FF; repeat (12) tick();
    set_rd(1'b1, 1'b1, 2'b10); tick();
    set_rd(1'b1, 1'b1, 2'b00);
    switch_i = 16'h00FE;
    repeat (4) begin
      tick();
      chk("glitch_stable", sif.switchrdata, 16'h00FF);
      chk("glitch_chg", {15'b0, switch_changed}, 16'h0000);
    end
    switch_i = 16'h00FF;
    repeat (14) begin
      tick();
      chk("glitch_stable", sif.switchrdata, 16'h00FF);
      chk("glitch_chg", {15'b0, switch_changed}, 16'h0000);
    end

    // 5. Set and clear on the same edge
    switch_i = 16'h0000; pulse_reset();
    switch_i = 16'h1234; set_rd(1'b1, 1'b1, 2'b00);
    repeat (10) tick();
    set_rd(1'b1, 1'b1, 2'b10);
    tick();
    chk("setclr_chg", {15'b0, switch_changed}, 16'h0001);
    chk("setclr_stat", sif.switchrdata, 16'h0001);
    tick();
    chk("setclr_after", {15'b0, switch_changed}, 16'h0000);
    set_rd(1'b1, 1'b1, 2'b00); #1;
    chk("setclr_data", sif.switchrdata, 16'h1234);

    // 6. Address / chip-select decode
    switch_i = 16'hBEEF; set_rd(1'b0, 1'b0, 2'b00);
    repeat (12) tick();
    chk("dec_chg", {15'b0, switch_changed}, 16'h0001);
    set_rd(1'b0, 1'b1, 2'b00); #1;
    chk("dec_nocs", sif.switchrdata, 16'h0000);
    set_rd(1'b1, 1'b1, 2'b01); #1;
    chk("dec_a01", sif.switchrdata, 16'h0000);
    tick();
    chk("dec_a01_chg", {15'b0, switch_changed}, 16'h0001);
    set_rd(1'b1, 1'b1, 2'b11); #1;
    chk("dec_a11", sif.switchrdata, 16'h0000);
    tick();
    set_rd(1'b1, 1'b1, 2'b00); #1;
    chk("dec_data", sif.switchrdata, 16'hBEEF);
    tick();
    chk("dec_data_chg", {15'b0, switch_changed}, 16'h0001);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 31);
      if (r == 0) switch_i = 16'($urandom);
      else if (r == 1) switch_i = switch_i ^ 16'(1 << $urandom_range(0, 15));
      set_rd(1'($urandom), 1'($urandom), 2'($urandom));
      if (i == 700) pulse_reset();
      else tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
